mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory byte-address width.
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports m0_req / m1_req  input  1  access request from master 0 (CPU data port) / master 1 (peripheral port).
REQ-006 SHALL have ports m0_we / m1_we  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports m0_addr / m1_addr  input  ADDR_W  access address.
REQ-008 SHALL have ports m0_wdata / m1_wdata  input  DATA_W  write data.
REQ-009 SHALL have ports m0_lock / m1_lock  input  1  hold ownership for atomic sequences.
REQ-010 SHALL have ports m0_gnt / m1_gnt  output  1  request accepted this cycle.
REQ-011 SHALL have ports m0_rvalid / m1_rvalid  output  1  read data valid, registered.
REQ-012 SHALL have ports m0_rdata / m1_rdata  output  DATA_W  read data, registered.
REQ-013 SHALL have port ram_addr  output  ADDR_W  RAM address.
REQ-014 SHALL have port ram_wdata  output  DATA_W  RAM write data.
REQ-015 SHALL have port ram_we  output  1  RAM write enable.
REQ-016 SHALL have port ram_rdata  input  DATA_W  RAM read data, valid exactly one cycle after the read address is presented.

Function
REQ-017 SHALL accept at most one request per cycle; gnt is combinational, at most one of m0_gnt/m1_gnt high.
REQ-018 SHALL, in the grant cycle, drive ram_addr/ram_wdata/ram_we from the granted master; ram_we = granted we; with no grant ram_we SHALL be 0 and ram_addr/ram_wdata SHALL hold their last driven values.
REQ-019 SHALL maintain a 1-bit last-owner register, updated to the granted master on every grant.
REQ-020 SHALL arbitrate: only one req -> grant it; both req -> grant the master not equal to last-owner (round robin).
REQ-021 SHALL override REQ-020: if last-owner's lock is high and its req is high, grant last-owner; if last-owner's lock is high and its req is low, grant nobody (other master stalls) until lock drops.
REQ-022 SHALL complete a write in the grant cycle; no rvalid is generated for writes.
REQ-023 SHALL, for a read granted in cycle N, register rd_pend=1 and rd_owner; in cycle N+1 assert owner rvalid for exactly one cycle with rdata = ram_rdata captured at the N+1 edge-to-edge window (visible from N+1 to N+2 edge).
REQ-024 SHALL allow a new grant in the same cycle a read response is returned (fully pipelined, one access per cycle sustained).
REQ-025 SHALL hold mX_rdata at its last value when mX_rvalid is low.
REQ-026 SHALL require masters to hold req/we/addr/wdata stable until gnt; a request dropped before gnt is discarded, no error.

Reset
REQ-027 SHALL, while rst is high, force m0_gnt=m1_gnt=0, ram_we=0, regardless of req.
REQ-028 SHALL, on rst, clear rd_pend, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, ram_addr, ram_wdata to 0 and set last-owner=1 (master 0 wins first tie).
REQ-029 SHALL drop a read in flight when rst is asserted; no rvalid after reset for it.

Verification
REQ-030 Reset then m0_req=m1_req=1 reads, addr 0x10/0x20 held -> cycle 1 m0_gnt, cycle 2 m1_gnt + m0_rvalid with RAM[0x10], cycle 3 m1_rvalid with RAM[0x20].
REQ-031 m0 write addr 0x40 data 0xDEADBEEF, then m1 read 0x40 -> ram_we=1 one cycle, m1_rvalid with rdata 0xDEADBEEF.
REQ-032 Both masters request continuously for 8 cycles -> grants alternate m0,m1,m0,... exactly 4 each, one rvalid per read, none lost.
REQ-033 m1 granted with m1_lock=1, m1_req low 2 cycles while m0_req=1 -> no grant those cycles; m1_lock drop -> m0_gnt next cycle.
REQ-034 rst asserted cycle after m0 read grant -> m0_rvalid stays 0, all outputs at reset values, first post-reset tie goes to m0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master arbiter in front of a single-port synchronous RAM.
// Masters: m0 = CPU data port, m1 = peripheral port. Grants are combinational;
// round robin on contention, with a lock that lets the last owner keep the RAM
// for atomic sequences. Reads return one cycle after grant, fully pipelined.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m1_req,
   input  logic              m0_we,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic              m0_lock,
   input  logic              m1_lock,
   output logic              m0_gnt,
   output logic              m1_gnt,
   output logic              m0_rvalid,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata
);

   typedef enum logic {
      OWN_M0 = 1'b0,
      OWN_M1 = 1'b1
   } owner_e;

   owner_e            last_owner;
   owner_e            rd_owner;
   logic              rd_pend;
   logic              any_gnt;
   logic [ADDR_W-1:0] ram_addr_q;
   logic [DATA_W-1:0] ram_wdata_q;
   logic [DATA_W-1:0] m0_rdata_q;
   logic [DATA_W-1:0] m1_rdata_q;

   // Grant selection: lock of the last owner overrides round robin.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path leaves it unassigned, which would otherwise infer a latch.
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
      if (!rst) begin
         if (last_owner == OWN_M1 && m1_lock) begin
            m1_gnt = m1_req;
         end else if (last_owner == OWN_M0 && m0_lock) begin
            m0_gnt = m0_req;
         end else if (m0_req && m1_req) begin
            if (last_owner == OWN_M1) m0_gnt = 1'b1;
            else                      m1_gnt = 1'b1;
         end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
         end
      end
   end

   assign any_gnt = m0_gnt | m1_gnt;

   // RAM port: granted master drives it, otherwise address/data hold.
   always_comb begin
      ram_we    = 1'b0;
      ram_addr  = ram_addr_q;
      ram_wdata = ram_wdata_q;
      if (m0_gnt) begin
         ram_we    = m0_we;
         ram_addr  = m0_addr;
         ram_wdata = m0_wdata;
      end else if (m1_gnt) begin
         ram_we    = m1_we;
         ram_addr  = m1_addr;
         ram_wdata = m1_wdata;
      end
   end

   // Ownership, held RAM port values, and read-pending tracking.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         last_owner  <= OWN_M1;
         rd_owner    <= OWN_M0;
         rd_pend     <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
      end else begin
         rd_pend <= (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);
         if (any_gnt) begin
            last_owner  <= m1_gnt ? OWN_M1 : OWN_M0;
            rd_owner    <= m1_gnt ? OWN_M1 : OWN_M0;
            ram_addr_q  <= ram_addr;
            ram_wdata_q <= ram_wdata;
         end
         if (m0_rvalid) m0_rdata_q <= ram_rdata;
         if (m1_rvalid) m1_rdata_q <= ram_rdata;
      end
   end

   // Read response: RAM data is steered to the owner in the return cycle and
   // retained afterwards; a response due during reset is suppressed.
   assign m0_rvalid = rd_pend & (rd_owner == OWN_M0) & ~rst;
   assign m1_rvalid = rd_pend & (rd_owner == OWN_M1) & ~rst;
   assign m0_rdata  = m0_rvalid ? ram_rdata : m0_rdata_q;
   assign m1_rdata  = m1_rvalid ? ram_rdata : m1_rdata_q;

endmodule
